// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO sizing constants and pointer-width helper
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 8;

  // Address bits plus one wrap bit that separates full from empty
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// rtl/fifo_ptr.sv - wrap-bit pointer counter with increment enable
module fifo_ptr #(
  parameter int PW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_datapath.sv
// rtl/fifo_datapath.sv - FIFO staging register, memory, pointers and status
// Optional sticky ovf/udf error flags enabled by FIFO_ERR_FLAGS_EN.
module fifo_datapath
  import fifo_pkg::*;
#(
  parameter int WIDTH  = FIFO_WIDTH,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  din,
  input  logic              ld1,
  input  logic              ld2,
  input  logic              ld3,
  output logic [WIDTH-1:0]  dout,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic              ovf,
  output logic              udf
`endif
);

  localparam int PTR_W = ptr_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_do;
  logic             rd_do;
  logic [WIDTH-1:0] in_reg_q;
  logic [WIDTH-1:0] dout_q;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Status depends on registered pointers only, never on the load strobes
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                 (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign wr_do = ld2 & ~full;
  assign rd_do = ld3 & ~empty;

  fifo_ptr #(.PW(PTR_W)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (wr_do),
    .ptr_o (wr_ptr)
  );

  fifo_ptr #(.PW(PTR_W)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .inc_i (rd_do),
    .ptr_o (rd_ptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_reg_q <= '0;
      dout_q   <= '0;
    end else begin
      if (ld1) begin
        in_reg_q <= din;
      end
      if (rd_do) begin
        dout_q <= mem_q[rd_ptr[ADDR_W-1:0]];
      end
    end
  end

  // Storage is deliberately unreset; only written locations are ever read
  always_ff @(posedge clk) begin
    if (wr_do) begin
      mem_q[wr_ptr[ADDR_W-1:0]] <= in_reg_q;
    end
  end

  assign dout = dout_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q;
  logic udf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ld2 & full) begin
        ovf_q <= 1'b1;
      end
      if (ld3 & empty) begin
        udf_q <= 1'b1;
      end
    end
  end

  assign ovf = ovf_q;
  assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_datapath.sv
// tb/tb_fifo_datapath.sv - directed table-driven bench for fifo_datapath
module tb_fifo_datapath;
  import fifo_pkg::*;

  localparam int W  = FIFO_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic          clk;
  logic          rst;
  logic [W-1:0]  din;
  logic          ld1;
  logic          ld2;
  logic          ld3;
  logic [W-1:0]  dout;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
  logic          ovf;
  logic          udf;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  fifo_datapath #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .din   (din),
    .ld1   (ld1),
    .ld2   (ld2),
    .ld3   (ld3),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
`ifdef FIFO_ERR_FLAGS_EN
    ,
    .ovf   (ovf),
    .udf   (udf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic         ld1;
    logic         ld2;
    logic         ld3;
    logic [W-1:0] din;
    logic [W-1:0] dout;
    logic [AW:0]  count;
    logic         full;
    logic         empty;
    logic         ovf;
    logic         udf;
  } vec_t;

  vec_t vecs [19];

  function automatic vec_t mk(input bit l1, input bit l2, input bit l3, input int d,
                              input int q, input int c, input bit f, input bit e,
                              input bit o, input bit u);
    vec_t v;
    v.ld1 = l1; v.ld2 = l2; v.ld3 = l3;
    v.din = W'(d); v.dout = W'(q); v.count = (AW+1)'(c);
    v.full = f; v.empty = e; v.ovf = o; v.udf = u;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input bit l1, input bit l2, input bit l3, input logic [W-1:0] d);
    ld1 = l1; ld2 = l2; ld3 = l3; din = d;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_status(input string tag, input int q, input int c, input bit f, input bit e);
    chk({tag, " dout"},  32'(dout),  32'(q));
    chk({tag, " count"}, 32'(count), 32'(c));
    chk({tag, " full"},  32'(full),  32'(f));
    chk({tag, " empty"}, 32'(empty), 32'(e));
  endtask

  initial begin
    // Fill 1..8 pipelined, drop a 9th write, drain 1..8, then read once while empty
    for (int k = 0; k <= 8; k++) begin
      vecs[k] = mk(1'b1, k != 0, 1'b0, k + 1, 0, k, k == 8, k == 0, 1'b0, 1'b0);
    end
    vecs[9] = mk(1'b0, 1'b1, 1'b0, 0, 0, 8, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int j = 10; j <= 17; j++) begin
      vecs[j] = mk(1'b0, 1'b0, 1'b1, 0, j - 9, 17 - j, 1'b0, j == 17, 1'b1, 1'b0);
    end
    vecs[18] = mk(1'b0, 1'b0, 1'b1, 0, 8, 0, 1'b0, 1'b1, 1'b1, 1'b1);

    rst = 1'b1; ld1 = 1'b0; ld2 = 1'b0; ld3 = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_status("reset", 0, 0, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("reset ovf", 32'(ovf), 32'd0);
    chk("reset udf", 32'(udf), 32'd0);
`endif
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 19; i++) begin
      step(vecs[i].ld1, vecs[i].ld2, vecs[i].ld3, vecs[i].din);
      chk_status($sformatf("vec%0d", i), int'(vecs[i].dout), int'(vecs[i].count),
                 vecs[i].full, vecs[i].empty);
`ifdef FIFO_ERR_FLAGS_EN
      chk($sformatf("vec%0d ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      chk($sformatf("vec%0d udf", i), 32'(udf), 32'(vecs[i].udf));
`endif
    end
    chk("fill wr_ptr", 32'(dut.wr_ptr), 32'd8);

    // Wrap: 10..14 through addresses 0..4 of the second lap
    step(1'b1, 1'b0, 1'b0, 8'd10);
    chk("wrap stage count", 32'(count), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 1'b0, W'(11 + i));
      chk($sformatf("wrap wr%0d count", i), 32'(count), 32'(i + 1));
    end
    chk("wrap wr_ptr", 32'(dut.wr_ptr), 32'd13);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      chk_status($sformatf("wrap rd%0d", i), 10 + i, 4 - i, 1'b0, i == 4);
    end
    chk("wrap rd_ptr", 32'(dut.rd_ptr), 32'd13);

    // Simultaneous while empty: write of staged 15 only, dout keeps 14
    step(1'b0, 1'b1, 1'b1, '0);
    chk_status("sim_empty", 14, 1, 1'b0, 1'b0);

    // Refill to full with 0x21..0x27 behind 15
    step(1'b1, 1'b0, 1'b0, 8'h21);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b1, 1'b0, W'(8'h22 + i));
      chk_status($sformatf("refill%0d", i), 14, 2 + i, i == 6, 1'b0);
    end
    chk("refill wr_ptr", 32'(dut.wr_ptr), 32'd5);

    // Simultaneous while full: read oldest (15), staged 0x28 dropped
    step(1'b0, 1'b1, 1'b1, '0);
    chk_status("sim_full", 15, 7, 1'b0, 1'b0);

    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1, '0);
      chk_status($sformatf("pre_steady%0d", i), 8'h21 + i, 6 - i, 1'b0, 1'b0);
    end

    // Steady state at count 4: writes 0x28.. behind 0x24..0x27
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, W'(8'h29 + i));
      chk($sformatf("steady%0d dout", i), 32'(dout), 32'(8'h24 + i));
      chk($sformatf("steady%0d count", i), 32'(count), 32'd4);
    end
    step(1'b0, 1'b0, 1'b1, '0);
    chk_status("post_steady", 8'h38, 3, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle with 3 entries stored
    ld1 = 1'b0; ld2 = 1'b0; ld3 = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_status("async_rst", 0, 0, 1'b0, 1'b1);
`ifdef FIFO_ERR_FLAGS_EN
    chk("async_rst ovf", 32'(ovf), 32'd0);
    chk("async_rst udf", 32'(udf), 32'd0);
`endif
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b1, '0);
    chk_status("rst_then_rd", 0, 0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_datapath.md
# fifo_datapath

Storage and pointer datapath for the streaming FIFO. Driven by the FIFO controller's load strobes (`ld1`, `ld2`, `ld3`). Returns the `full` and `empty` status that the controller uses to generate `ready` and `valid`. Holds the input staging register, the circular memory, the read/write pointers and the output register.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits
- `DEPTH`, 8, number of entries; must be a power of two, at least 2
- `ADDR_W`, `$clog2(DEPTH)`, derived; not overridden by instantiators

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  asynchronous, active-high reset
- `din`  in  WIDTH  write data from upstream producer
- `ld1`  in  1  capture `din` into the input register `in_reg`
- `ld2`  in  1  write `in_reg` to `mem[wr_ptr]`, advance write pointer
- `ld3`  in  1  load `mem[rd_ptr]` into `dout`, advance read pointer
- `dout`  out  WIDTH  registered read data
- `full`  out  1  FIFO holds DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH

## Operation
- **Pointers:** `wr_ptr` and `rd_ptr` are ADDR_W+1 bits wide. The low ADDR_W bits are the address; the MSB is a wrap bit. Increment is modulo 2^(ADDR_W+1).
- **empty:** `wr_ptr == rd_ptr`.
- **full:** MSBs differ and the low ADDR_W bits are equal.
- **count:** `wr_ptr - rd_ptr`, computed in ADDR_W+1 bits.
- **Output derivation:** `full`, `empty` and `count` are combinational from the registered pointers only. There is no path from `ld*` or `din` to these outputs.
- **Effective write:** `wr_do = ld2 & ~full`. A write when full is dropped; memory and `wr_ptr` are unchanged.
- **Effective read:** `rd_do = ld3 & ~empty`. A read when empty is dropped; `dout` and `rd_ptr` hold.
- **Qualification:** both qualifiers use pre-edge `full` and `empty`.
  - Simultaneous `ld2` and `ld3` when full: only the read occurs.
  - Simultaneous `ld2` and `ld3` when empty: only the write occurs.
  - Simultaneous `ld2` and `ld3` otherwise: both occur and `count` is unchanged.
- **`ld1` with `ld2` in the same cycle:** memory receives the old `in_reg` value; `in_reg` takes the new `din`.
- **Memory:** `mem` has no reset. Its contents are undefined until written, and no read of an unwritten location is possible.
- **Reset values:** `wr_ptr` 0, `rd_ptr` 0, `in_reg` 0, `dout` 0.
  - Resulting outputs: `empty` 1, `full` 0, `count` 0.
- **Reset during operation:** reset discards all stored entries immediately (asynchronous). The first post-reset edge behaves as it does from a cold reset.

## Timing
- **`ld1` to memory:** `din` sampled at edge N by `ld1` is available for `ld2` from edge N+1. The earliest write into memory is therefore at edge N+1.
- **Write to read:** a write at edge N makes `empty` deassert after edge N. A `ld3` sampled at edge N+1 can read that entry.
- **Read latency:** `dout` is valid from the edge at which `ld3` is sampled, i.e. one cycle of read latency.
- **Throughput:** sustained throughput is one write and one read per cycle.
- **Status update:** `full`/`empty` change in the same cycle as the pointer update that causes them; no additional lag.

## Configuration
- **Macro:** `FIFO_ERR_FLAGS_EN`.
- **Defined:** adds output ports `ovf` and `udf` (each 1 bit, reset 0).
  - `ovf` sets sticky on any `ld2 & full`.
  - `udf` sets sticky on any `ld3 & empty`.
  - Both clear only on `rst`.
- **Undefined:** the ports and logic are absent. All other behaviour is identical.

## Structure
- **Package `fifo_pkg`:**
  - default `WIDTH`/`DEPTH` constants shared with the controller and testbench
  - a pointer-width function returning `$clog2(DEPTH)+1`
- **Sub-module `fifo_ptr`:** a pointer counter with wrap bit, and an increment-enable input. Instantiated twice: write pointer enabled by `wr_do`, read pointer enabled by `rd_do`.
- **Top level:** `mem`, `in_reg`, `dout`, the flag logic and the optional error flags stay in `fifo_datapath`.

## Test plan
- **Reset:** assert `rst` mid-stream with 3 entries stored → `empty`=1, `full`=0, `count`=0, `dout`=0 immediately (asynchronous). Apply `ld3` after release → `dout` stays 0.
- **Fill:** with DEPTH=8, `ld1`+`ld2` pipelined with `din`=1..8 → `full`=1 after the 8th write, `count`=8. A 9th `ld2` with `din`=9 is dropped and `ovf`=1 when the macro is defined.
- **Drain and wrap:** read 8 entries → `dout` sequence 1..8, then `empty`=1. Write and read 5 more (10..14) → correct order across the address wrap, and the pointer MSBs toggle.
- **Simultaneous access when full:** `ld2` and `ld3` together while full → one read (`dout`=oldest entry), write dropped, `count` goes 8→7.
- **Simultaneous access when empty:** `ld2` and `ld3` together while empty → write only, `count` goes 0→1, `dout` unchanged. A `ld3` while empty sets `udf`=1 when the macro is defined.
- **Steady state:** simultaneous `ld2` and `ld3` at `count`=4 for 20 cycles → `count` stays 4 and data order is preserved.
